// File: rtl/vec_pkg.sv
// Shared definitions for the vector encryption processor decode stage:
// sizes, opcode encodings, instruction field positions and an opcode
// classification helper used by the decoder.
package vec_pkg;

   localparam int NREGS = 8;   // number of vector registers
   localparam int VW    = 32;  // register width: 4 lanes x 8 bits
   localparam int RW    = 3;   // register index width

   // Opcode encodings
   localparam logic [3:0] OP_NOP   = 4'd0;
   localparam logic [3:0] OP_VXOR  = 4'd1;
   localparam logic [3:0] OP_VSHL  = 4'd2;
   localparam logic [3:0] OP_VSHR  = 4'd3;
   localparam logic [3:0] OP_VROTL = 4'd4;
   localparam logic [3:0] OP_VROTR = 4'd5;
   localparam logic [3:0] OP_VADD  = 4'd6;
   localparam logic [3:0] OP_VSUB  = 4'd7;
   localparam logic [3:0] OP_VLD   = 4'd8;
   localparam logic [3:0] OP_VST   = 4'd9;
   localparam logic [3:0] OP_HALT  = 4'd15;

   // Instruction field bit positions
   localparam int OPC_HI = 13;
   localparam int OPC_LO = 10;
   localparam int RD_HI  = 9;
   localparam int RD_LO  = 7;
   localparam int RS1_HI = 6;
   localparam int RS1_LO = 4;
   localparam int RS2_HI = 3;
   localparam int RS2_LO = 1;
   localparam int IMM_HI = 6;
   localparam int IMM_LO = 0;

   // Register usage of one opcode
   typedef struct packed {
      logic reads_a;   // port A carries a real source operand
      logic reads_b;   // port B carries a real source operand
      logic writes;    // instruction produces a result in rd
      logic is_st;     // port A is addressed by the [9:7] field (store)
      logic is_halt;   // instruction stops the stage
   } dec_t;

   // Classify an opcode by the registers it reads and writes
   function automatic dec_t decode_class(input logic [3:0] opc);
      dec_t d;
      d = '{reads_a: 1'b0, reads_b: 1'b0, writes: 1'b0, is_st: 1'b0, is_halt: 1'b0};
      case (opc)
         OP_VXOR, OP_VADD, OP_VSUB: begin
            d.reads_a = 1'b1;
            d.reads_b = 1'b1;
            d.writes  = 1'b1;
         end
         OP_VSHL, OP_VSHR, OP_VROTL, OP_VROTR: begin
            d.reads_a = 1'b1;
            d.writes  = 1'b1;
         end
         OP_VLD: begin
            d.writes  = 1'b1;
         end
         OP_VST: begin
            d.reads_a = 1'b1;
            d.is_st   = 1'b1;
         end
         OP_HALT: begin
            d.is_halt = 1'b1;
         end
         default: begin
            // NOP and the unassigned encodings touch no registers
            d.reads_a = 1'b0;
         end
      endcase
      return d;
   endfunction

endpackage

// File: rtl/banco_registros_vec.sv
// 8 x VW vector register file: two combinational read ports, one write
// port. A write in progress is forwarded to the read ports in the same
// cycle so decode never sees a stale value.
module banco_registros_vec
   import vec_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [RW-1:0] raddr_a,
   input  logic [RW-1:0] raddr_b,
   output logic [VW-1:0] rdata_a,
   output logic [VW-1:0] rdata_b,
   input  logic          we,
   input  logic [RW-1:0] waddr,
   input  logic [VW-1:0] wdata
);

   logic [VW-1:0] mem_r [NREGS];
   logic          byp_a_s;
   logic          byp_b_s;

   // Storage: clear every register on reset, otherwise apply write-back
   always_ff @(posedge clk) begin
      if (reset) begin
         for (int i = 0; i < NREGS; i++) begin
            mem_r[i] <= {VW{1'b0}};
         end
      end else if (we) begin
         mem_r[waddr] <= wdata;
      end
   end

   // Bypass detection: the port address matches the register being written
   always_comb begin
      byp_a_s = we && (waddr == raddr_a);
      byp_b_s = we && (waddr == raddr_b);
   end

   // Read port A with write-back forwarding
   always_comb begin
      if (byp_a_s) begin
         rdata_a = wdata;
      end else begin
         rdata_a = mem_r[raddr_a];
      end
   end

   // Read port B with write-back forwarding
   always_comb begin
      if (byp_b_s) begin
         rdata_b = wdata;
      end else begin
         rdata_b = mem_r[raddr_b];
      end
   end

endmodule

// File: rtl/etapa_id.sv
// Instruction-decode stage: splits the fetch word into fields, reads the
// operands, tracks pending destination writes in a busy scoreboard,
// raises stall on RAW/WAW hazards and registers the ID/EX bundle.
module etapa_id
   import vec_pkg::*;
(
   input  logic          clk,
   input  logic          reset,
   input  logic [13:0]   instruccion,
   input  logic          flush,
   input  logic          wb_we,
   input  logic [RW-1:0] wb_addr,
   input  logic [VW-1:0] wb_data,
   output logic          stall,
   output logic          halted,
   output logic          ex_valid,
   output logic [3:0]    ex_opcode,
   output logic [RW-1:0] ex_rd,
   output logic [VW-1:0] ex_op_a,
   output logic [VW-1:0] ex_op_b,
   output logic [6:0]    ex_imm
);

   // Decoded fields of the current word
   logic [3:0]       opcode_s;
   logic [RW-1:0]    rd_s;
   logic [RW-1:0]    rs1_s;
   logic [RW-1:0]    rs2_s;
   logic [6:0]       imm_s;
   dec_t             dec_s;
   logic [RW-1:0]    addr_a_s;

   // Operand data from the register file
   logic [VW-1:0]    rdata_a_s;
   logic [VW-1:0]    rdata_b_s;

   // Scoreboard and hazard logic
   logic [NREGS-1:0] busy_r;
   logic [NREGS-1:0] wb_clr_s;
   logic [NREGS-1:0] busy_clr_s;
   logic [NREGS-1:0] busy_set_s;
   logic             haz_a_s;
   logic             haz_b_s;
   logic             haz_rd_s;
   logic             stall_s;
   logic             issue_s;

   // Stage state and ID/EX register
   logic             halted_r;
   logic             ex_valid_r;
   logic [3:0]       ex_opcode_r;
   logic [RW-1:0]    ex_rd_r;
   logic [VW-1:0]    ex_op_a_r;
   logic [VW-1:0]    ex_op_b_r;
   logic [6:0]       ex_imm_r;

   // Field extraction and opcode classification
   always_comb begin
      opcode_s = instruccion[OPC_HI:OPC_LO];
      rd_s     = instruccion[RD_HI:RD_LO];
      rs1_s    = instruccion[RS1_HI:RS1_LO];
      rs2_s    = instruccion[RS2_HI:RS2_LO];
      imm_s    = instruccion[IMM_HI:IMM_LO];
      dec_s    = decode_class(opcode_s);
   end

   // Port A reads the [9:7] field for stores, rs1 for everything else
   always_comb begin
      if (dec_s.is_st) begin
         addr_a_s = rd_s;
      end else begin
         addr_a_s = rs1_s;
      end
   end

   banco_registros_vec u_banco (
      .clk     (clk),
      .reset   (reset),
      .raddr_a (addr_a_s),
      .raddr_b (rs2_s),
      .rdata_a (rdata_a_s),
      .rdata_b (rdata_b_s),
      .we      (wb_we),
      .waddr   (wb_addr),
      .wdata   (wb_data)
   );

   // One-hot mask of the register released by this cycle's write-back
   always_comb begin
      if (wb_we) begin
         wb_clr_s = {{(NREGS-1){1'b0}}, 1'b1} << wb_addr;
      end else begin
         wb_clr_s = {NREGS{1'b0}};
      end
   end

   // Busy view used for hazards: write-back releases before the check,
   // so a result arriving this cycle is consumed through the bypass
   always_comb begin
      busy_clr_s = busy_r & ~wb_clr_s;
   end

   // Hazard terms: busy sources (RAW) and busy destination (WAW)
   always_comb begin
      haz_a_s  = dec_s.reads_a && busy_clr_s[addr_a_s];
      haz_b_s  = dec_s.reads_b && busy_clr_s[rs2_s];
      haz_rd_s = dec_s.writes  && busy_clr_s[rd_s];
   end

   // Stall only for a live word; flush and halt both mask it
   always_comb begin
      if (flush || halted_r) begin
         stall_s = 1'b0;
      end else begin
         stall_s = haz_a_s || haz_b_s || haz_rd_s;
      end
   end

   // A word issues when it is live and free of hazards
   always_comb begin
      issue_s = !flush && !halted_r && !stall_s;
   end

   // Destination reservation for an issuing writer
   always_comb begin
      if (issue_s && dec_s.writes) begin
         busy_set_s = {{(NREGS-1){1'b0}}, 1'b1} << rd_s;
      end else begin
         busy_set_s = {NREGS{1'b0}};
      end
   end

   // Scoreboard update: release on write-back, reserve on issue (reserve wins)
   always_comb begin : sb_dummy
   end

   always_ff @(posedge clk) begin
      if (reset) begin
         busy_r <= {NREGS{1'b0}};
      end else begin
         busy_r <= busy_clr_s | busy_set_s;
      end
   end

   // Sticky halt flag, set once a HALT has issued
   always_ff @(posedge clk) begin
      if (reset) begin
         halted_r <= 1'b0;
      end else if (issue_s && dec_s.is_halt) begin
         halted_r <= 1'b1;
      end else begin
         halted_r <= halted_r;
      end
   end

   // ID/EX register: load on issue, otherwise bubble and hold the payload
   always_ff @(posedge clk) begin
      if (reset) begin
         ex_valid_r  <= 1'b0;
         ex_opcode_r <= 4'd0;
         ex_rd_r     <= {RW{1'b0}};
         ex_op_a_r   <= {VW{1'b0}};
         ex_op_b_r   <= {VW{1'b0}};
         ex_imm_r    <= 7'd0;
      end else if (issue_s) begin
         ex_valid_r  <= 1'b1;
         ex_opcode_r <= opcode_s;
         ex_rd_r     <= rd_s;
         ex_op_a_r   <= rdata_a_s;
         ex_op_b_r   <= rdata_b_s;
         ex_imm_r    <= imm_s;
      end else begin
         ex_valid_r  <= 1'b0;
      end
   end

   assign stall     = stall_s;
   assign halted    = halted_r;
   assign ex_valid  = ex_valid_r;
   assign ex_opcode = ex_opcode_r;
   assign ex_rd     = ex_rd_r;
   assign ex_op_a   = ex_op_a_r;
   assign ex_op_b   = ex_op_b_r;
   assign ex_imm    = ex_imm_r;

endmodule

// File: tb/tb_etapa_id.sv
// Self-checking bench for etapa_id: a reference model predicts every
// cycle's stall and ID/EX bundle; predictions are queued when a word is
// driven and compared once the clock edge has produced the DUT output.
module tb_etapa_id;

   logic        clk = 1'b0;
   logic        reset;
   logic [13:0] instruccion;
   logic        flush;
   logic        wb_we;
   logic [2:0]  wb_addr;
   logic [31:0] wb_data;
   logic        stall;
   logic        halted;
   logic        ex_valid;
   logic [3:0]  ex_opcode;
   logic [2:0]  ex_rd;
   logic [31:0] ex_op_a;
   logic [31:0] ex_op_b;
   logic [6:0]  ex_imm;

   etapa_id dut (
      .clk         (clk),
      .reset       (reset),
      .instruccion (instruccion),
      .flush       (flush),
      .wb_we       (wb_we),
      .wb_addr     (wb_addr),
      .wb_data     (wb_data),
      .stall       (stall),
      .halted      (halted),
      .ex_valid    (ex_valid),
      .ex_opcode   (ex_opcode),
      .ex_rd       (ex_rd),
      .ex_op_a     (ex_op_a),
      .ex_op_b     (ex_op_b),
      .ex_imm      (ex_imm)
   );

   always #5 clk = ~clk;

   typedef struct packed {
      logic        valid;
      logic [3:0]  opc;
      logic [2:0]  rd;
      logic [31:0] a;
      logic [31:0] b;
      logic [6:0]  imm;
      logic        halted;
   } exp_t;

   exp_t        exp_q[$];
   int          n_checks = 0;
   int          n_errors = 0;

   // Reference model state
   logic [31:0] m_regs [8];
   logic [7:0]  m_busy;
   logic        m_halted;
   exp_t        m_hold;
   logic        seen_stall;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      if (obs !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h expected %h", tag, obs, exp);
      end
   endtask

   function automatic logic [31:0] m_read(input logic [2:0] a, input logic we,
                                         input logic [2:0] wa, input logic [31:0] wd);
      if (we && wa == a) return wd;
      return m_regs[a];
   endfunction

   task automatic model_reset();
      for (int i = 0; i < 8; i++) m_regs[i] = 32'd0;
      m_busy   = 8'd0;
      m_halted = 1'b0;
      m_hold   = '0;
      exp_q.delete();
   endtask

   task automatic do_reset();
      @(negedge clk);
      reset = 1'b1; instruccion = 14'd0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = 3'd0; wb_data = 32'd0;
      @(posedge clk);
      @(posedge clk);
      #1;
      model_reset();
      check("rst_ex_valid",  {31'd0, ex_valid}, 32'd0);
      check("rst_ex_opcode", {28'd0, ex_opcode}, 32'd0);
      check("rst_ex_rd",     {29'd0, ex_rd}, 32'd0);
      check("rst_ex_op_a",   ex_op_a, 32'd0);
      check("rst_ex_op_b",   ex_op_b, 32'd0);
      check("rst_ex_imm",    {25'd0, ex_imm}, 32'd0);
      check("rst_halted",    {31'd0, halted}, 32'd0);
      @(negedge clk);
      reset = 1'b0;
      #1;
      check("rst_stall", {31'd0, stall}, 32'd0);
   endtask

   // Drive one word for one cycle, predict, then compare after the edge
   task automatic step(input logic [13:0] ins, input logic fl, input logic we,
                       input logic [2:0] wa, input logic [31:0] wd);
      logic [3:0] opc;
      logic [2:0] rd, rs1, rs2, addr_a;
      logic       ra, rb, wr, st;
      logic [7:0] clr, bc;
      logic       exp_stall, iss;
      exp_t       e;
      @(negedge clk);
      instruccion = ins; flush = fl; wb_we = we; wb_addr = wa; wb_data = wd;
      opc = ins[13:10]; rd = ins[9:7]; rs1 = ins[6:4]; rs2 = ins[3:1];
      ra = 1'b0; rb = 1'b0; wr = 1'b0; st = 1'b0;
      case (opc)
         4'd1, 4'd6, 4'd7: begin ra = 1'b1; rb = 1'b1; wr = 1'b1; end
         4'd2, 4'd3, 4'd4, 4'd5: begin ra = 1'b1; wr = 1'b1; end
         4'd8: wr = 1'b1;
         4'd9: begin ra = 1'b1; st = 1'b1; end
         default: ;
      endcase
      addr_a = st ? rd : rs1;
      clr = we ? (8'd1 << wa) : 8'd0;
      bc  = m_busy & ~clr;
      exp_stall = !fl && !m_halted &&
                  ((ra && bc[addr_a]) || (rb && bc[rs2]) || (wr && bc[rd]));
      iss = !fl && !m_halted && !exp_stall;
      if (iss) begin
         m_hold.opc = opc;
         m_hold.rd  = rd;
         m_hold.a   = m_read(addr_a, we, wa, wd);
         m_hold.b   = m_read(rs2, we, wa, wd);
         m_hold.imm = ins[6:0];
      end
      if (we) m_regs[wa] = wd;
      m_busy = bc | ((iss && wr) ? (8'd1 << rd) : 8'd0);
      if (iss && opc == 4'd15) m_halted = 1'b1;
      e = m_hold;
      e.valid  = iss;
      e.halted = m_halted;
      exp_q.push_back(e);
      #1;
      seen_stall = stall;
      check("stall", {31'd0, stall}, {31'd0, exp_stall});
      @(posedge clk);
      #1;
      if (exp_q.size() == 0) begin
         check("queue_empty", 32'd0, 32'd1);
      end else begin
         e = exp_q.pop_front();
         check("ex_valid",  {31'd0, ex_valid}, {31'd0, e.valid});
         check("ex_opcode", {28'd0, ex_opcode}, {28'd0, e.opc});
         check("ex_rd",     {29'd0, ex_rd}, {29'd0, e.rd});
         check("ex_op_a",   ex_op_a, e.a);
         check("ex_op_b",   ex_op_b, e.b);
         check("ex_imm",    {25'd0, ex_imm}, {25'd0, e.imm});
         check("halted",    {31'd0, halted}, {31'd0, e.halted});
      end
   endtask

   localparam logic [13:0] I_NOP = 14'd0;

   initial begin
      logic [13:0] r_ins;
      reset = 1'b1; instruccion = 14'd0; flush = 1'b0;
      wb_we = 1'b0; wb_addr = 3'd0; wb_data = 32'd0;
      do_reset();

      // VXOR r1,r2,r3 on a cleared file
      step({4'd1, 3'd1, 3'd2, 3'd3, 1'b0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_vxor_valid", {31'd0, ex_valid}, 32'd1);
      check("plan_vxor_opa", ex_op_a, 32'd0);

      // Write-back r2, then VSHL r4,r2,imm=3
      step(I_NOP, 1'b0, 1'b1, 3'd2, 32'hA5A5A5A5);
      step({4'd2, 3'd4, 7'h23}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_vshl_opa", ex_op_a, 32'hA5A5A5A5);
      check("plan_vshl_sh", {29'd0, ex_imm[2:0]}, 32'd3);

      // VADD r5,r1,r1 stalls on busy r1 until the write-back arrives
      step({4'd6, 3'd5, 3'd1, 3'd1, 1'b0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_vadd_stall", {31'd0, seen_stall}, 32'd1);
      step({4'd6, 3'd5, 3'd1, 3'd1, 1'b0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_vadd_bubble", {31'd0, ex_valid}, 32'd0);
      step({4'd6, 3'd5, 3'd1, 3'd1, 1'b0}, 1'b0, 1'b1, 3'd1, 32'h01020304);
      check("plan_vadd_go", {31'd0, seen_stall}, 32'd0);
      check("plan_vadd_opb", ex_op_b, 32'h01020304);

      // Flushed VLD r6 must not reserve r6
      step({4'd8, 3'd6, 7'd0}, 1'b1, 1'b0, 3'd0, 32'd0);
      step({4'd9, 3'd6, 7'd0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_flush_nobusy", {31'd0, seen_stall}, 32'd0);

      // Same-cycle VLD r7 issue and write-back r7: reservation wins
      step({4'd8, 3'd7, 7'd0}, 1'b0, 1'b1, 3'd7, 32'h77777777);
      step({4'd9, 3'd7, 7'd0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_setwins_stall", {31'd0, seen_stall}, 32'd1);
      step({4'd9, 3'd7, 7'd0}, 1'b0, 1'b1, 3'd7, 32'hCAFEF00D);
      check("plan_vst_opa", ex_op_a, 32'hCAFEF00D);

      // Mixed traffic with random write-backs and flushes
      for (int k = 0; k < 80; k++) begin
         r_ins = 14'($urandom);
         if (r_ins[13:10] == 4'd15) r_ins[13:10] = 4'd0;
         step(r_ins, ($urandom_range(0, 5) == 0), 1'($urandom_range(0, 1)),
              3'($urandom_range(0, 7)), $urandom);
      end

      // HALT then more words: one valid entry, then bubbles
      step({4'd15, 10'd0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_halt_valid", {31'd0, ex_valid}, 32'd1);
      check("plan_halt_opc", {28'd0, ex_opcode}, 32'd15);
      for (int k = 0; k < 3; k++) begin
         step({4'd1, 3'd0, 3'd0, 3'd0, 1'b0}, 1'b0, 1'b0, 3'd0, 32'd0);
      end
      check("plan_halted", {31'd0, halted}, 32'd1);
      check("plan_halt_bubble", {31'd0, ex_valid}, 32'd0);
      do_reset();

      // Reset in flight drops reservations; late write-back is harmless
      step({4'd8, 3'd3, 7'd0}, 1'b0, 1'b0, 3'd0, 32'd0);
      do_reset();
      step(I_NOP, 1'b0, 1'b1, 3'd3, 32'h13572468);
      step({4'd9, 3'd3, 7'd0}, 1'b0, 1'b0, 3'd0, 32'd0);
      check("plan_rst_nostall", {31'd0, seen_stall}, 32'd0);
      check("plan_rst_opa", ex_op_a, 32'h13572468);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
